// File: rtl/mc_risk_pkg.sv
// mc_risk_pkg: shared definitions for the Monte Carlo risk readout path.
//   - Default core count, accumulator width and log2(paths per option)
//   - Collector FSM state encoding
//   - Result entry layout {idx, sum, mean} at the default widths
package mc_risk_pkg;

    localparam int unsigned CoreNDef    = 2;
    localparam int unsigned AccWidthDef = 27;
    localparam int unsigned LogPathsDef = 11;
    localparam int unsigned IdxWidthDef = 8;
    localparam int unsigned SumWidthDef = AccWidthDef + $clog2(CoreNDef);

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StSum     = 2'd1,
        StPush    = 2'd2
    } state_e;

    typedef struct packed {
        logic [IdxWidthDef-1:0] idx;
        logic [SumWidthDef-1:0] sum;
        logic [AccWidthDef-1:0] mean;
    } result_t;

endpackage

// File: rtl/mc_result_fifo.sv
// mc_result_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst    : clock, synchronous active-high reset
//   wr_en/wr_data : write request; accepted when not full, or when a read
//                   happens in the same cycle
//   rd_en       : pop the head (ignored when empty)
//   rd_data     : head entry, straight from the storage registers
//   full/empty  : occupancy flags derived from the count register
module mc_result_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic [Width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_wr, do_rd;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

    // A write while full is still accepted when the head leaves this cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mc_result_collector.sv
// mc_result_collector: gathers per-core Monte Carlo accumulators, forms the
// cross-core sum and rounded per-path mean, and queues {idx, sum, mean}.
//   CLK, RST   : clock, synchronous active-high reset
//   iAcc       : core accumulators, core k at [k*AccWidth +: AccWidth]
//   iDone      : per-core one-cycle done pulse qualifying its iAcc slice
//   oValid     : result FIFO head valid; iReady pops it
//   oIdx/oSum/oMean : head entry fields
//   oBusy      : a round is in progress (not idle or some core reported)
//   oOverflow  : sticky, a result was dropped on a full FIFO
//   oProtoErr  : sticky, a core reported twice in one round
module mc_result_collector
    import mc_risk_pkg::*;
#(
    parameter int unsigned CoreN     = CoreNDef,
    parameter int unsigned AccWidth  = AccWidthDef,
    parameter int unsigned LogPaths  = LogPathsDef,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned IdxWidth  = IdxWidthDef,
    localparam int unsigned SumW     = AccWidth + $clog2(CoreN)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CoreN*AccWidth-1:0] iAcc,
    input  logic [CoreN-1:0]          iDone,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [IdxWidth-1:0]       oIdx,
    output logic [SumW-1:0]           oSum,
    output logic [AccWidth-1:0]       oMean,
    output logic                      oBusy,
    output logic                      oOverflow,
    output logic                      oProtoErr
);

    localparam int unsigned EntryW = IdxWidth + SumW + AccWidth;

    state_e              state_q;
    logic [CoreN-1:0]    got_q, got_next;
    logic [AccWidth-1:0] latch_q [CoreN];
    logic [SumW-1:0]     sum_q, sum_next;
    logic [AccWidth-1:0] mean_q, mean_next;
    logic [SumW:0]       round_sum;
    logic [IdxWidth-1:0] idx_q;
    logic                overflow_q, proto_err_q;
    logic                dup_done;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [EntryW-1:0]   fifo_head;

    // Cross-core sum and round-half-up mean; one extra bit for the rounding add.
    always_comb begin
        sum_next = '0;
        for (int k = 0; k < CoreN; k++) begin
            sum_next = sum_next + SumW'(latch_q[k]);
        end
        round_sum = {1'b0, sum_next} + ((SumW + 1)'(1) << (LogPaths - 1));
        mean_next = AccWidth'(round_sum >> LogPaths);
    end

    // The SUM cycle closes the round: a done arriving then opens the next one
    // and is therefore not a duplicate.
    always_comb begin
        got_next = (state_q == StSum) ? '0 : got_q;
        got_next = got_next | iDone;
    end

    assign dup_done = (state_q != StSum) && (|(got_q & iDone));

    assign fifo_push = (state_q == StPush);
    assign fifo_pop  = !fifo_empty && iReady;
    assign drop      = fifo_push && fifo_full && !fifo_pop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StCollect;
            got_q   <= '0;
            for (int k = 0; k < CoreN; k++) begin
                latch_q[k] <= '0;
            end
            sum_q       <= '0;
            mean_q      <= '0;
            idx_q       <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            got_q <= got_next;
            for (int k = 0; k < CoreN; k++) begin
                if (iDone[k]) begin
                    latch_q[k] <= iAcc[k*AccWidth +: AccWidth];
                end
            end
            if (dup_done) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                StCollect: begin
                    if (&got_q) begin
                        state_q <= StSum;
                    end
                end
                StSum: begin
                    sum_q   <= sum_next;
                    mean_q  <= mean_next;
                    state_q <= StPush;
                end
                StPush: begin
                    // Index advances even when the entry is dropped.
                    idx_q <= idx_q + 1'b1;
                    if (drop) begin
                        overflow_q <= 1'b1;
                    end
                    state_q <= StCollect;
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    mc_result_fifo #(
        .Width (EntryW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (fifo_push),
        .wr_data ({idx_q, sum_q, mean_q}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign oValid             = !fifo_empty;
    assign {oIdx, oSum, oMean} = fifo_head;
    assign oBusy              = (state_q != StCollect) || (|got_q);
    assign oOverflow          = overflow_q;
    assign oProtoErr          = proto_err_q;

endmodule

// File: tb/tb_mc_result_collector.sv
// Bench for mc_result_collector: directed table, multi-cycle corner cases and
// a randomized phase scored against a queue of expected results.
module tb_mc_result_collector;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [53:0] iAcc = '0;
    logic [1:0]  iDone = '0;
    logic        iReady = 1'b0;
    logic        oValid;
    logic [7:0]  oIdx;
    logic [27:0] oSum;
    logic [26:0] oMean;
    logic        oBusy, oOverflow, oProtoErr;

    int n_checks = 0;
    int n_fail   = 0;
    bit prod_done = 1'b0;

    typedef struct {
        logic [26:0] a0;
        logic [26:0] a1;
        int          order;   // 0: core0 first, 1: core1 first, 2: same cycle
        int          gap;
        logic [27:0] exp_sum;
        logic [26:0] exp_mean;
    } vec_t;

    typedef struct {
        int     idx;
        longint sum;
        longint mean;
    } ent_t;

    vec_t vecs[7];
    ent_t exp_q[$];

    mc_result_collector dut (
        .CLK       (CLK),
        .RST       (RST),
        .iAcc      (iAcc),
        .iDone     (iDone),
        .oValid    (oValid),
        .iReady    (iReady),
        .oIdx      (oIdx),
        .oSum      (oSum),
        .oMean     (oMean),
        .oBusy     (oBusy),
        .oOverflow (oOverflow),
        .oProtoErr (oProtoErr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Round-half-up mean over 2048 paths.
    function automatic longint ref_mean(input longint s);
        return (s + 1024) / 2048;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Slices of cores not pulsing carry junk that must be ignored.
    task automatic done_pulse(input logic [1:0] mask, input logic [26:0] a0,
                              input logic [26:0] a1);
        iDone        = mask;
        iAcc[26:0]   = mask[0] ? a0 : 27'($urandom);
        iAcc[53:27]  = mask[1] ? a1 : 27'($urandom);
        tick();
        iDone = '0;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        iDone  = '0;
        iReady = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic pop_one();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
    endtask

    task automatic issue_round(input logic [26:0] a0, input logic [26:0] a1,
                               input int order, input int gap);
        case (order)
            0: begin done_pulse(2'b01, a0, '0); ticks(gap); done_pulse(2'b10, '0, a1); end
            1: begin done_pulse(2'b10, '0, a1); ticks(gap); done_pulse(2'b01, a0, '0); end
            default: done_pulse(2'b11, a0, a1);
        endcase
    endtask

    task automatic producer();
        logic [26:0] a0, a1;
        longint      s;
        int          w;
        int          idx = 0;
        for (int r = 0; r < 40; r++) begin
            a0 = (r % 8 == 0) ? 27'h7FF_FFFF : 27'($urandom);
            a1 = (r % 8 == 1) ? 27'h7FF_FFFF : 27'($urandom);
            s  = longint'(a0) + longint'(a1);
            exp_q.push_back('{idx, s, ref_mean(s)});
            idx = (idx + 1) % 256;
            issue_round(a0, a1, $urandom_range(0, 2), $urandom_range(0, 4));
            w = 0;
            while (oBusy && w < 30) begin
                tick();
                w++;
            end
            chk("busy_timeout", oBusy, 0);
        end
        prod_done = 1'b1;
    endtask

    task automatic consumer();
        ent_t e;
        int   guard = 0;
        while ((!prod_done || exp_q.size() != 0) && guard < 5000) begin
            iReady = ($urandom_range(0, 3) != 0) || (exp_q.size() >= 2);
            if (oValid && iReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", oValid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_idx", oIdx, e.idx);
                    chk("rand_sum", oSum, e.sum);
                    chk("rand_mean", oMean, e.mean);
                end
            end
            tick();
            guard++;
        end
        iReady = 1'b0;
        chk("rand_drained", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{27'd1000, 27'd3000, 0, 9, 28'd4000, 27'd2};
        vecs[1] = '{27'h7FF_FFFF, 27'h7FF_FFFF, 2, 0, 28'd268435454, 27'd131072};
        vecs[2] = '{27'd0, 27'd0, 2, 0, 28'd0, 27'd0};
        vecs[3] = '{27'd1023, 27'd0, 1, 0, 28'd1023, 27'd0};
        vecs[4] = '{27'd1024, 27'd0, 0, 2, 28'd1024, 27'd1};
        vecs[5] = '{27'd3071, 27'd1, 1, 3, 28'd3072, 27'd2};
        vecs[6] = '{27'd5000, 27'd7000, 0, 0, 28'd12000, 27'd6};

        // Reset state
        do_reset();
        chk("rst_valid", oValid, 0);
        chk("rst_idx", oIdx, 0);
        chk("rst_sum", oSum, 0);
        chk("rst_mean", oMean, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_overflow", oOverflow, 0);
        chk("rst_protoerr", oProtoErr, 0);

        // Table: last done at c, oValid exactly at c+4
        for (int i = 0; i < 7; i++) begin
            issue_round(vecs[i].a0, vecs[i].a1, vecs[i].order, vecs[i].gap);
            tick();
            chk("tbl_busy_sum", oBusy, 1);
            tick();
            chk("tbl_valid_early", oValid, 0);
            tick();
            chk("tbl_valid", oValid, 1);
            chk("tbl_idx", oIdx, i);
            chk("tbl_sum", oSum, vecs[i].exp_sum);
            chk("tbl_mean", oMean, vecs[i].exp_mean);
            pop_one();
            chk("tbl_popped", oValid, 0);
        end

        // Overflow: 5 options with no consumer
        do_reset();
        for (int i = 0; i < 5; i++) begin
            done_pulse(2'b11, 27'((i + 1) * 1000), 27'((i + 1) * 1000));
            ticks(4);
            if (i == 3) chk("ovf_not_yet", oOverflow, 0);
        end
        chk("ovf_flag", oOverflow, 1);
        ticks(3);
        chk("ovf_head_stable", oIdx, 0);
        for (int j = 0; j < 4; j++) begin
            chk("ovf_drain_valid", oValid, 1);
            chk("ovf_drain_idx", oIdx, j);
            chk("ovf_drain_sum", oSum, 2000 * (j + 1));
            pop_one();
        end
        chk("ovf_empty", oValid, 0);
        done_pulse(2'b11, 27'd7, 27'd7);
        ticks(3);
        chk("ovf_next_valid", oValid, 1);
        chk("ovf_next_idx", oIdx, 5);
        chk("ovf_next_sum", oSum, 14);
        chk("ovf_sticky", oOverflow, 1);
        pop_one();

        // Duplicate done
        do_reset();
        done_pulse(2'b01, 27'd10, '0);
        ticks(2);
        chk("dup_before", oProtoErr, 0);
        done_pulse(2'b01, 27'd20, '0);
        chk("dup_flag", oProtoErr, 1);
        ticks(2);
        done_pulse(2'b10, '0, 27'd30);
        ticks(3);
        chk("dup_valid", oValid, 1);
        chk("dup_sum", oSum, 50);
        chk("dup_mean", oMean, 0);
        pop_one();

        // Core0 done during the SUM cycle belongs to the next option
        do_reset();
        done_pulse(2'b01, 27'd1000000, '0);
        tick();
        done_pulse(2'b10, '0, 27'd2000000);
        tick();
        done_pulse(2'b01, 27'd5000, '0);
        chk("sumcyc_busy", oBusy, 1);
        tick();
        chk("sumcyc_valid", oValid, 1);
        chk("sumcyc_idx", oIdx, 0);
        chk("sumcyc_sum", oSum, 3000000);
        chk("sumcyc_mean", oMean, 1465);
        pop_one();
        chk("sumcyc_pending", oBusy, 1);
        done_pulse(2'b10, '0, 27'd7);
        ticks(3);
        chk("sumcyc_next_valid", oValid, 1);
        chk("sumcyc_next_idx", oIdx, 1);
        chk("sumcyc_next_sum", oSum, 5007);
        chk("sumcyc_next_mean", oMean, 2);
        pop_one();

        // Reset mid-round discards the partial capture
        do_reset();
        done_pulse(2'b01, 27'd111, '0);
        do_reset();
        done_pulse(2'b10, '0, 27'd222);
        ticks(6);
        chk("midrst_no_result", oValid, 0);
        chk("midrst_busy", oBusy, 1);
        done_pulse(2'b01, 27'd333, '0);
        ticks(3);
        chk("midrst_valid", oValid, 1);
        chk("midrst_idx", oIdx, 0);
        chk("midrst_sum", oSum, 555);
        chk("midrst_overflow", oOverflow, 0);
        chk("midrst_protoerr", oProtoErr, 0);
        pop_one();

        // Randomized rounds with a randomly stalling consumer
        do_reset();
        fork
            producer();
            consumer();
        join
        chk("rand_overflow", oOverflow, 0);
        chk("rand_protoerr", oProtoErr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
